wb_mem_arbiter: RTL
===================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 3, number of Wishbone B3 masters (index 0 = or1k_i, 1 = or1k_d, 2 = dbg).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, slave-silence cycles before a bus error is forced.
REQ-005 SHALL have port wb_clk_i, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port wb_rst_n_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports m_adr_i/m_dat_i, input, NUM_M*AW / NUM_M*DW, packed master address/write data.
REQ-008 SHALL have ports m_sel_i, input, NUM_M*4; m_we_i/m_cyc_i/m_stb_i, input, NUM_M each; m_cti_i, input, NUM_M*3; m_bte_i, input, NUM_M*2.
REQ-009 SHALL have ports m_dat_o, output, NUM_M*DW; m_ack_o/m_err_o/m_rty_o, output, NUM_M each.
REQ-010 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o, outputs, toward the shared slave (main RAM).
REQ-011 SHALL have ports s_dat_i, input, DW; s_ack_i/s_err_i/s_rty_i, input, 1.
REQ-012 SHALL have port grant_o, output, NUM_M, one-hot current owner (zero when idle).

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> (IDLE | TOUT); TOUT -> IDLE after one cycle.
REQ-014 IDLE: when any m_cyc_i is high, SHALL register a grant next cycle and enter BUSY; s_cyc_o rises in that cycle (1-cycle arbitration latency).
REQ-015 Selection SHALL be round-robin: search starts at index after last owner, wraps from NUM_M-1 to 0; after reset last owner = NUM_M-1 (master 0 first).
REQ-016 BUSY: slave request signals SHALL be combinational mux of owner's inputs; s_cyc_o = owner m_cyc_i.
REQ-017 BUSY: s_ack_i/s_err_i/s_rty_i and s_dat_i SHALL route only to owner; non-owners see ack/err/rty = 0, dat = 0.
REQ-018 Grant SHALL be held while owner m_cyc_i is high, including across incrementing bursts (cti 3'b010); no preemption.
REQ-019 BUSY -> IDLE when owner m_cyc_i drops, or on the ack cycle with owner cti = 3'b111; grant_o clears that next cycle.
REQ-020 A requester other than the owner SHALL wait; back-to-back handover costs exactly one IDLE cycle.
REQ-021 Watchdog counter SHALL reset to 0 on any s_ack_i/s_err_i/s_rty_i or when not BUSY, increment each BUSY cycle with owner stb high.
REQ-022 Counter reaching TIMEOUT SHALL enter TOUT: owner m_err_o = 1 for exactly one cycle, s_cyc_o/s_stb_o = 0, then IDLE; counter width = clog2(TIMEOUT+1).
REQ-023 Owner dropping m_cyc_i in the same cycle as timeout SHALL suppress the err pulse and go straight to IDLE.
REQ-024 Simultaneous new requests at IDLE SHALL be resolved only by round-robin order; m_stb_i without m_cyc_i SHALL be ignored.

Reset
REQ-025 On wb_rst_n_i low, asynchronously: state = IDLE, grant_o = 0, last owner = NUM_M-1, counter = 0, all s_* request outputs and m_ack_o/m_err_o/m_rty_o = 0.
REQ-026 Reset asserted mid-burst SHALL abort the transfer immediately; no ack is delivered after deassertion.
REQ-027 Reset deassertion SHALL be synchronised externally; the block samples no inputs while reset is low.

Structure
REQ-028 State encoding and CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111) SHALL live in shared package wb_arb_pkg.
REQ-029 Round-robin selection SHALL be sub-module wb_rr_pick (request vector + last-owner in, one-hot winner out, purely combinational).
REQ-030 Grant, FSM and watchdog SHALL be registered; datapath muxes combinational; target 150-300 lines.

Verification
REQ-031 Single classic read by master 1 at 0x100, slave acks after 2 cycles with 0xDEADBEEF -> m_dat_o[1] = 0xDEADBEEF, m_ack_o[1] once, grant_o 3'b010 then 3'b000.
REQ-032 Masters 0,1,2 request together in the same cycle, each one classic access -> grant order 0,1,2, one idle cycle between grants.
REQ-033 Master 0 issues 8-beat INCR burst (cti 010 x7, 111 last) while master 2 requests -> master 2 granted only after the 8th ack.
REQ-034 Slave never acks, TIMEOUT = 15 -> m_err_o of owner pulses once at cycle 16 of BUSY, state returns IDLE, next requester granted.
REQ-035 wb_rst_n_i pulsed low during beat 3 of a 4-beat burst -> all outputs 0 immediately; after release, master 0 wins first.
REQ-036 Slave s_err_i during master 2 write -> only m_err_o[2] high, m_ack_o all 0, watchdog cleared.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared encodings for the Wishbone main-memory arbiter: FSM states and
// cycle-type identifiers.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TOUT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Width of an index able to name any of n masters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin winner selection: the search starts one past the last owner
// and wraps, so every requester is reached within NUM_M grants.
module wb_rr_pick #(
    parameter int NUM_M = 3,
    parameter int IW    = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [NUM_M-1:0] grant,
    output logic [IW-1:0]    grant_idx
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = last;
        found     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_M; off++) begin
            cand = int'(last) + off;
            if (cand >= NUM_M) cand = cand - NUM_M;
            for (int k = 0; k < NUM_M; k++) begin
                if (!found && k == cand && req[k]) begin
                    found     = 1'b1;
                    grant[k]  = 1'b1;
                    grant_idx = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Wishbone B3 arbiter sharing one slave (main RAM) among NUM_M masters with
// round-robin ownership, whole-cycle grants and a slave-silence watchdog.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic [NUM_M*AW-1:0] m_adr_i,
    input  logic [NUM_M*DW-1:0] m_dat_i,
    input  logic [NUM_M*4-1:0]  m_sel_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M*3-1:0]  m_cti_i,
    input  logic [NUM_M*2-1:0]  m_bte_i,
    output logic [NUM_M*DW-1:0] m_dat_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_M-1:0]    m_rty_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic [2:0]          s_cti_o,
    output logic [1:0]          s_bte_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    output logic [NUM_M-1:0]    grant_o,
    output arb_state_t          state_dbg
);

    localparam int IW = idx_width(NUM_M);
    localparam int CW = $clog2(TIMEOUT + 1);

    // Handshake: a master requests with cyc&stb held until the slave answers
    // with exactly one of ack/err/rty in the same cycle; that cycle completes
    // the beat. cyc alone (stb low) keeps ownership without issuing a beat.

    arb_state_t       state;
    logic [IW-1:0]    owner;  // current owner in BUSY/TOUT, last owner otherwise
    logic [NUM_M-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic [CW-1:0]    wdog;
    logic [CW-1:0]    wdog_next;
    logic             owner_cyc;
    logic             owner_stb;
    logic [2:0]       owner_cti;
    logic             slave_resp;

    wb_rr_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_rr_pick (
        .req       (m_cyc_i),
        .last      (owner),
        .grant     (pick),
        .grant_idx (pick_idx)
    );

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_cti = CTI_CLASSIC;
        for (int i = 0; i < NUM_M; i++) begin
            if (owner == IW'(i)) begin
                owner_cyc = m_cyc_i[i];
                owner_stb = m_cyc_i[i] & m_stb_i[i];
                owner_cti = m_cti_i[i*3 +: 3];
            end
        end
    end

    assign slave_resp = s_ack_i | s_err_i | s_rty_i;
    assign wdog_next  = wdog + 1'b1;
    assign state_dbg  = state;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state   <= ST_IDLE;
            grant_o <= '0;
            owner   <= IW'(NUM_M - 1);
            wdog    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (|m_cyc_i) begin
                        state   <= ST_BUSY;
                        grant_o <= pick;
                        owner   <= pick_idx;
                    end
                end
                ST_BUSY: begin
                    // Owner leaving wins over a coincident timeout: no err pulse.
                    if (!owner_cyc || (s_ack_i && owner_cti == CTI_EOB)) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                        wdog    <= '0;
                    end else if (slave_resp) begin
                        wdog <= '0;
                    end else if (owner_stb) begin
                        wdog <= wdog_next;
                        if (wdog_next == CW'(TIMEOUT)) state <= ST_TOUT;
                    end
                end
                ST_TOUT: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                    wdog    <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                    wdog    <= '0;
                end
            endcase
        end
    end

    // Request path follows the owner only while BUSY; responses reach the owner only.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = CTI_CLASSIC;
        s_bte_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (owner == IW'(i)) begin
                if (state == ST_BUSY) begin
                    s_adr_o = m_adr_i[i*AW +: AW];
                    s_dat_o = m_dat_i[i*DW +: DW];
                    s_sel_o = m_sel_i[i*4 +: 4];
                    s_we_o  = m_we_i[i];
                    s_cyc_o = m_cyc_i[i];
                    s_stb_o = m_cyc_i[i] & m_stb_i[i];
                    s_cti_o = m_cti_i[i*3 +: 3];
                    s_bte_o = m_bte_i[i*2 +: 2];
                    m_dat_o[i*DW +: DW] = s_dat_i;
                    m_ack_o[i] = s_ack_i;
                    m_err_o[i] = s_err_i;
                    m_rty_o[i] = s_rty_i;
                end else if (state == ST_TOUT) begin
                    m_err_o[i] = 1'b1;
                end
            end
        end
    end

endmodule
